nco_tuning_controller: RTL and testbench

Converts a user frequency/waveform request into a 32-bit phase-increment (tuning word) for the NCO phase accumulator, and loads it with a one-cycle strobe. It sits between the top-level UI sequencer and the phase accumulator/waveform lookup. Requests are accepted only while the UI sequencer is in its waveform-generation state. The multiply is a sequential shift-add, so no hardware multiplier is needed.

---
 rtl/nco_tuning_controller.sv | 145 ++++++++++++++
 tb/tb_nco_tuning_controller.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/nco_tuning_controller.sv
// Turns a frequency/waveform request into an NCO tuning word (freq * K) using a shift-add multiply.
// Optional `NCO_GLIDE_EN: ramps tw_out toward the new word by GLIDE_STEP once per millisecond.
module nco_tuning_controller #(
  parameter int unsigned FREQ_W     = 20,
  parameter int unsigned TW_W       = 32,
  parameter int unsigned K          = 4295,
  parameter int unsigned F_MAX      = 500000,
  parameter int unsigned GLIDE_STEP = 429500
) (
  input  logic              clk_1MHz,
  input  logic              rst,
  input  logic              enable,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [FREQ_W-1:0] req_freq,
  input  logic [1:0]        req_wave,
  output logic [TW_W-1:0]   tw_out,
  output logic [1:0]        wave_out,
  output logic              tw_load,
  output logic              busy,
  output logic              err
);

  localparam int unsigned PW     = FREQ_W + 13;
  localparam logic [12:0] K_BITS = 13'(K);

`ifdef NCO_GLIDE_EN
  typedef enum logic [2:0] {IDLE, CHECK, MULT, LOAD, GLIDE} state_t;
`else
  typedef enum logic [1:0] {IDLE, CHECK, MULT, LOAD} state_t;
`endif

  state_t            state;
  logic [FREQ_W-1:0] freq;
  logic [1:0]        wave;
  logic [TW_W-1:0]   acc;
  logic [3:0]        idx;
  logic [TW_W-1:0]   addend;

`ifdef NCO_GLIDE_EN
  logic [9:0]        tick;
  logic [TW_W-1:0]   target;
  logic [TW_W-1:0]   next_tw;

  // Step toward target, clamping so the final step lands exactly on it.
  always_comb begin
    next_tw = tw_out;
    if (target > tw_out) begin
      if (target - tw_out <= TW_W'(GLIDE_STEP)) next_tw = target;
      else                                      next_tw = tw_out + TW_W'(GLIDE_STEP);
    end else if (target < tw_out) begin
      if (tw_out - target <= TW_W'(GLIDE_STEP)) next_tw = target;
      else                                      next_tw = tw_out - TW_W'(GLIDE_STEP);
    end
  end
`endif

  // Product is FREQ_W+13 bits; the legal maximum fits in TW_W, so truncation is safe.
  always_comb begin
    addend = '0;
    if (K_BITS[idx]) addend = TW_W'(PW'(freq) << idx);
  end

  assign req_ready = (state == IDLE) && enable;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      state    <= IDLE;
      freq     <= '0;
      wave     <= '0;
      acc      <= '0;
      idx      <= '0;
      tw_out   <= '0;
      wave_out <= '0;
      tw_load  <= 1'b0;
      err      <= 1'b0;
`ifdef NCO_GLIDE_EN
      tick     <= '0;
      target   <= '0;
`endif
    end else begin
      tw_load <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            freq  <= req_freq;
            wave  <= req_wave;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (!enable) begin
            state <= IDLE;
          end else if (freq == '0 || freq > FREQ_W'(F_MAX)) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            acc   <= '0;
            idx   <= '0;
            state <= MULT;
          end
        end
        MULT: begin
          if (!enable) begin
            state <= IDLE;
          end else begin
            acc <= acc + addend;
            idx <= idx + 4'd1;
            if (idx == 4'd12) state <= LOAD;
          end
        end
        LOAD: begin
          wave_out <= wave;
          tw_load  <= 1'b1;
`ifdef NCO_GLIDE_EN
          target   <= acc;
          tick     <= '0;
          state    <= (acc == tw_out) ? IDLE : GLIDE;
`else
          tw_out   <= acc;
          state    <= IDLE;
`endif
        end
`ifdef NCO_GLIDE_EN
        GLIDE: begin
          if (!enable) begin
            state <= IDLE;
          end else if (tick == 10'd999) begin
            tick    <= '0;
            tw_out  <= next_tw;
            tw_load <= 1'b1;
            if (next_tw == target) state <= IDLE;
          end else begin
            tick <= tick + 10'd1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nco_tuning_controller.sv
// Directed bench for nco_tuning_controller (default build): latency, limits, reject, abort and reset.
`timescale 1ns/1ps
module tb_nco_tuning_controller;

  logic        clk_1MHz = 1'b0;
  logic        rst;
  logic        enable;
  logic        req_valid;
  logic        req_ready;
  logic [19:0] req_freq;
  logic [1:0]  req_wave;
  logic [31:0] tw_out;
  logic [1:0]  wave_out;
  logic        tw_load;
  logic        busy;
  logic        err;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  nco_tuning_controller #(.FREQ_W(20), .TW_W(32), .K(4295), .F_MAX(500000), .GLIDE_STEP(429500)) dut (
    .clk_1MHz (clk_1MHz),
    .rst      (rst),
    .enable   (enable),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_freq (req_freq),
    .req_wave (req_wave),
    .tw_out   (tw_out),
    .wave_out (wave_out),
    .tw_load  (tw_load),
    .busy     (busy),
    .err      (err)
  );

  always #500 clk_1MHz = ~clk_1MHz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_1MHz);
    #1;
  endtask

  // Full accepted request: handshake, 14 busy cycles, load on the 15th edge.
  task automatic run_req(input logic [19:0] f, input logic [1:0] w,
                         input logic [31:0] exp_tw, input string tag);
    check({tag, " ready"}, 32'(req_ready), 1);
    req_valid = 1'b1; req_freq = f; req_wave = w;
    step();
    req_valid = 1'b0; req_freq = '1; req_wave = ~w;
    for (int i = 0; i < 14; i++) step();
    check({tag, " busy pre-load"}, 32'(busy), 1);
    check({tag, " no early load"}, 32'(tw_load), 0);
    step();
    check({tag, " tw_out"}, tw_out, exp_tw);
    check({tag, " wave_out"}, 32'(wave_out), 32'(w));
    check({tag, " tw_load"}, 32'(tw_load), 1);
    check({tag, " idle"}, 32'(busy), 0);
    step();
    check({tag, " tw_load 1-cycle"}, 32'(tw_load), 0);
  endtask

  task automatic reject(input logic [19:0] f, input string tag);
    req_valid = 1'b1; req_freq = f; req_wave = 2'd0;
    step();
    req_valid = 1'b0;
    step();
    check({tag, " err"}, 32'(err), 1);
    check({tag, " no load"}, 32'(tw_load), 0);
    step();
    check({tag, " err 1-cycle"}, 32'(err), 0);
    check({tag, " ready"}, 32'(req_ready), 1);
    check({tag, " tw held"}, tw_out, 32'd2147500000 + 32'd0 - 32'd2147495705);
    check({tag, " wave held"}, 32'(wave_out), 3);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; req_valid = 1'b0; req_freq = '0; req_wave = '0;
    step(); step();
    rst = 1'b0;
    step();
    check("reset tw_out", tw_out, 0);
    check("reset wave_out", 32'(wave_out), 0);
    check("reset tw_load", 32'(tw_load), 0);
    check("reset err", 32'(err), 0);
    check("reset busy", 32'(busy), 0);
    check("ready enable low", 32'(req_ready), 0);

    enable = 1'b1;
    #1;
    run_req(20'd1000, 2'd2, 32'd4295000, "f1000");

    // 500 kHz with a 1 Hz request held pending through the whole conversion
    req_valid = 1'b1; req_freq = 20'd500000; req_wave = 2'd1;
    step();
    req_freq = 20'd1; req_wave = 2'd3;
    for (int i = 0; i < 14; i++) begin
      step();
      check("ready low while busy", 32'(req_ready), 0);
    end
    step();
    check("fmax tw_out", tw_out, 32'd2147500000);
    check("fmax wave_out", 32'(wave_out), 1);
    check("fmax tw_load", 32'(tw_load), 1);
    check("ready after load", 32'(req_ready), 1);
    step();
    req_valid = 1'b0;
    check("pending accepted", 32'(busy), 1);
    check("fmax load 1-cycle", 32'(tw_load), 0);
    for (int i = 0; i < 14; i++) step();
    check("f1 no early load", 32'(tw_load), 0);
    step();
    check("f1 tw_out", tw_out, 32'd4295);
    check("f1 wave_out", 32'(wave_out), 3);
    check("f1 tw_load", 32'(tw_load), 1);
    step();

    reject(20'd500001, "f500001");
    reject(20'd0, "f0");

    // Requests are ignored while enable is low
    enable = 1'b0; req_valid = 1'b1; req_freq = 20'd1000;
    #1;
    check("ready enable low 2", 32'(req_ready), 0);
    step(); step();
    check("no accept enable low", 32'(busy), 0);

    // Abort after the fifth MULT edge
    enable = 1'b1; req_wave = 2'd1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("mult busy", 32'(busy), 1);
    enable = 1'b0;
    step();
    check("abort idle", 32'(busy), 0);
    check("abort no err", 32'(err), 0);
    for (int i = 0; i < 12; i++) begin
      step();
      check("abort no load", 32'(tw_load), 0);
    end
    check("abort tw held", tw_out, 32'd4295);
    enable = 1'b1;
    #1;
    check("ready restored", 32'(req_ready), 1);

    // Reset mid-MULT after a prior load
    run_req(20'd1000, 2'd0, 32'd4295000, "f1000 again");
    req_valid = 1'b1; req_freq = 20'd2000; req_wave = 2'd2;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst tw_out", tw_out, 0);
    check("rst wave_out", 32'(wave_out), 0);
    check("rst busy", 32'(busy), 0);
    check("rst tw_load", 32'(tw_load), 0);
    run_req(20'd777, 2'd1, 32'd3337215, "f777");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
